multicycle_control_unit: RTL

Parametrised multi-cycle successor to the single-cycle main decoder. It sequences each RV32I instruction through FETCH, DECODE, EXEC, MEM and WB states and drives datapath enables one cycle at a time. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register's opcode field and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the shared-memory RV32I datapath.
// The FSM sequences FETCH, DECODE, EXEC, MEM and WB, stalls on the memory ready handshake,
// and counts retired instructions. The control outputs are decoded combinationally from
// the state and the registered instruction class, and are forced low while reset is high.
module multicycle_control_unit #(
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               IRWrite,
    output logic               IorD,
    output logic               ALUSrc,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsR  = 3'd0,
        ClsI  = 3'd1,
        ClsLd = 3'd2,
        ClsSt = 3'd3,
        ClsBr = 3'd4
    } cls_e;

    localparam logic [6:0] OpR  = 7'b0110011;
    localparam logic [6:0] OpI  = 7'b0010011;
    localparam logic [6:0] OpLd = 7'b0000011;
    localparam logic [6:0] OpSt = 7'b0100011;
    localparam logic [6:0] OpBr = 7'b1100011;

    state_e           state_q;
    cls_e             cls_q;
    logic [CNT_W-1:0] instret_q;

    logic             ready;
    logic             dec_legal;
    cls_e             dec_cls;

    // With MEM_WAIT = 0 the memory always completes in one cycle.
    assign ready = (MEM_WAIT == 0) || mem_ready;

    // Classify the opcode presented during DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = ClsR;
        case (opcode)
            OpR:     dec_cls = ClsR;
            OpI:     dec_cls = ClsI;
            OpLd:    dec_cls = ClsLd;
            OpSt:    dec_cls = ClsSt;
            OpBr:    dec_cls = ClsBr;
            default: dec_legal = 1'b0;
        endcase
    end

    // State sequencing, class capture and the retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsR;
            instret_q <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (ready) state_q <= StDecode;
                end
                StDecode: begin
                    if (dec_legal) begin
                        cls_q   <= dec_cls;
                        state_q <= StExec;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StExec: begin
                    case (cls_q)
                        ClsBr: begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                        ClsLd, ClsSt: state_q <= StMem;
                        default:      state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (ready) begin
                        if (cls_q == ClsLd) begin
                            state_q <= StWb;
                        end else begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                    end
                end
                StWb: begin
                    state_q   <= StFetch;
                    instret_q <= instret_q + CNT_W'(1);
                end
                // Codes 5-7 cannot be reached; recover to FETCH.
                default: state_q <= StFetch;
            endcase
        end
    end

    // Datapath enables; everything is held low while reset is asserted so a stalled write
    // is withdrawn in the same cycle reset rises.
    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        ALUop    = '0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    if (ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                StDecode: begin
                    illegal = !dec_legal;
                end
                StExec: begin
                    case (cls_q)
                        ClsR: begin
                            ALUop = ALUOP_W'(2'b10);
                        end
                        ClsI: begin
                            ALUSrc = 1'b1;
                            ALUop  = ALUOP_W'(2'b11);
                        end
                        ClsLd, ClsSt: begin
                            ALUSrc = 1'b1;
                        end
                        ClsBr: begin
                            ALUop   = ALUOP_W'(2'b01);
                            Branch  = 1'b1;
                            PCSrc   = 1'b1;
                            PCWrite = zero;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    IorD     = 1'b1;
                    MemRead  = (cls_q == ClsLd);
                    MemWrite = (cls_q == ClsSt);
                end
                StWb: begin
                    RegWrite = 1'b1;
                    MemToReg = (cls_q == ClsLd);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
